// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRANT   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             preempted;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  preempted
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output preempted
  );
endinterface

// File: rtl/rr_pick_8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 8.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   offset;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign doubled = {req, req};
  assign rotated = doubled[ptr +: N_REQ];
  assign any     = |rotated;

  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = IDX_W'(i);
      end
    end
  end

  assign idx = offset + ptr;
endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered grant, hold-limit preemption
// and a one-cycle break-before-make gap between owners.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic           clk,
  input  logic           reset,
  rr_arbiter_8_if.slave  bus
);
  // Counter stops at the last allowed cycle; with no limit it simply saturates.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [HOLD_W-1:0] hold;
  logic [N_REQ-1:0] grant_r;
  logic             valid_r;
  logic             preempted_r;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             timeout;

  rr_pick_8 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req = bus.req[owner];
  assign timeout   = (MAX_HOLD != 0) && (hold == HOLD_SAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      hold        <= '0;
      grant_r     <= '0;
      valid_r     <= 1'b0;
      preempted_r <= 1'b0;
    end else begin
      preempted_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state   <= ST_GRANT;
            owner   <= pick_idx;
            grant_r <= idx_to_onehot(pick_idx);
            valid_r <= 1'b1;
            hold    <= '0;
          end
        end
        ST_GRANT: begin
          // A dropped request wins over a simultaneous timeout, so preempted only
          // flags exits where the owner still wanted the resource.
          if (!owner_req || timeout) begin
            state       <= ST_RELEASE;
            preempted_r <= owner_req;
            ptr         <= owner + IDX_W'(1);
            owner       <= '0;
            grant_r     <= '0;
            valid_r     <= 1'b0;
            hold        <= '0;
          end else if (hold != HOLD_SAT) begin
            hold <= hold + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_idx   = owner;
  assign bus.grant_valid = valid_r;
  assign bus.preempted   = preempted_r;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: two instances (hold limits 4 and 16) checked every cycle
// against a behavioural ownership model, plus directed literal checks.
module tb_rr_arbiter_8;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'hFF;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_8_if bus0 ();
  rr_arbiter_8_if bus1 ();

  assign bus0.req = req;
  assign bus1.req = req;

  rr_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(5)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Model: who owns the resource, how long they have had it, whether we are in the
  // mandatory gap, and where the next search starts.
  int hold_limit [2] = '{4, 16};
  int owner      [2] = '{-1, -1};
  int held       [2] = '{0, 0};
  int gap        [2] = '{0, 0};
  int ptr        [2] = '{0, 0};
  bit pre        [2] = '{1'b0, 1'b0};
  bit model_live = 1'b0;

  task automatic model_step(input int d);
    int w;
    pre[d] = 1'b0;
    if (reset) begin
      owner[d] = -1;
      held[d]  = 0;
      gap[d]   = 0;
      ptr[d]   = 0;
    end else if (owner[d] >= 0) begin
      held[d]++;
      if (!req[owner[d]] || held[d] == hold_limit[d]) begin
        pre[d]   = req[owner[d]];
        ptr[d]   = (owner[d] + 1) % 8;
        owner[d] = -1;
        gap[d]   = 1;
      end
    end else if (gap[d] != 0) begin
      gap[d] = 0;
    end else begin
      w = -1;
      for (int k = 0; k < 8; k++) begin
        if (w < 0 && req[(ptr[d] + k) % 8]) w = (ptr[d] + k) % 8;
      end
      if (w >= 0) begin
        owner[d] = w;
        held[d]  = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
    model_live = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(input int d, input logic [7:0] g, input logic [2:0] gi,
                             input logic gv, input logic p);
    logic [31:0] eg;
    eg = (owner[d] >= 0) ? (32'h1 << owner[d]) : 32'h0;
    check_output($sformatf("dut%0d grant", d), {24'h0, g}, eg);
    check_output($sformatf("dut%0d grant_idx", d), {29'h0, gi}, (owner[d] >= 0) ? owner[d] : 0);
    check_output($sformatf("dut%0d grant_valid", d), {31'h0, gv}, {31'h0, owner[d] >= 0});
    check_output($sformatf("dut%0d preempted", d), {31'h0, p}, {31'h0, pre[d]});
    check_output($sformatf("dut%0d onehot", d), {31'h0, $countones(g) <= 1}, 32'h1);
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      compare_dut(0, bus0.grant, bus0.grant_idx, bus0.grant_valid, bus0.preempted);
      compare_dut(1, bus1.grant, bus1.grant_idx, bus1.grant_valid, bus1.preempted);
    end
  end

  task automatic apply_stimulus(input logic [7:0] r, input logic rst);
    req   = r;
    reset = rst;
  endtask

  initial begin
    int          seq [$];
    int          pre_count;
    int          cnt;
    logic        prev;

    // Reset held two cycles with every request high.
    apply_stimulus(8'hFF, 1'b1);
    @(negedge clk);
    check_output("reset grant c1", {24'h0, bus0.grant}, 32'h0);
    check_output("reset valid c1", {31'h0, bus0.grant_valid}, 32'h0);
    @(negedge clk);
    check_output("reset grant c2", {24'h0, bus0.grant}, 32'h0);
    apply_stimulus(8'hFF, 1'b0);
    @(negedge clk);
    check_output("first grant d0", {24'h0, bus0.grant}, 32'h01);
    check_output("first grant d1", {24'h0, bus1.grant}, 32'h01);

    // Rotation on the hold-limit-4 instance.
    seq.push_back(int'(bus0.grant_idx));
    prev = 1'b1;
    pre_count = 0;
    for (int c = 0; c < 80 && seq.size() < 9; c++) begin
      @(negedge clk);
      if (bus0.preempted) pre_count++;
      if (bus0.grant_valid && !prev) seq.push_back(int'(bus0.grant_idx));
      prev = bus0.grant_valid;
    end
    check_output("rotation count", seq.size(), 9);
    for (int i = 0; i < seq.size(); i++) check_output($sformatf("rotation owner %0d", i), seq[i], i % 8);
    check_output("rotation preempt pulses", pre_count, 8);

    // Voluntary release: bit 2 drops during its third grant cycle.
    apply_stimulus(8'h24, 1'b1);
    @(negedge clk);
    apply_stimulus(8'h24, 1'b0);
    @(negedge clk);
    check_output("vol c1", {24'h0, bus0.grant}, 32'h04);
    @(negedge clk);
    check_output("vol c2", {24'h0, bus0.grant}, 32'h04);
    @(negedge clk);
    check_output("vol c3", {24'h0, bus0.grant}, 32'h04);
    apply_stimulus(8'h20, 1'b0);
    @(negedge clk);
    check_output("vol release grant", {24'h0, bus0.grant}, 32'h0);
    check_output("vol release preempted", {31'h0, bus0.preempted}, 32'h0);
    @(negedge clk);
    check_output("vol idle grant", {24'h0, bus0.grant}, 32'h0);
    @(negedge clk);
    check_output("vol next owner d0", {24'h0, bus0.grant}, 32'h20);
    check_output("vol next owner d1", {24'h0, bus1.grant}, 32'h20);

    // Pointer wrap: owner 7 leaves with bits 0 and 7 requesting.
    apply_stimulus(8'h80, 1'b1);
    @(negedge clk);
    apply_stimulus(8'h80, 1'b0);
    @(negedge clk);
    check_output("wrap owner d0", {29'h0, bus0.grant_idx}, 32'd7);
    check_output("wrap owner d1", {29'h0, bus1.grant_idx}, 32'd7);
    apply_stimulus(8'h81, 1'b0);
    repeat (4) @(negedge clk);
    check_output("wrap preempt d0", {31'h0, bus0.preempted}, 32'h1);
    repeat (2) @(negedge clk);
    check_output("wrap winner d0", {24'h0, bus0.grant}, 32'h01);
    repeat (10) @(negedge clk);
    check_output("wrap preempt d1", {31'h0, bus1.preempted}, 32'h1);
    repeat (2) @(negedge clk);
    check_output("wrap winner d1", {24'h0, bus1.grant}, 32'h01);

    // Single persistent requester on the hold-limit-16 instance.
    apply_stimulus(8'h08, 1'b1);
    @(negedge clk);
    apply_stimulus(8'h08, 1'b0);
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus1.grant == 8'h08) cnt++;
    end
    check_output("persist hold cycles", cnt, 16);
    @(negedge clk);
    check_output("persist preempt", {31'h0, bus1.preempted}, 32'h1);
    check_output("persist gap grant", {24'h0, bus1.grant}, 32'h0);
    repeat (2) @(negedge clk);
    check_output("persist regrant", {24'h0, bus1.grant}, 32'h08);

    // Reset during the fifth grant cycle of owner 3.
    repeat (4) @(negedge clk);
    apply_stimulus(8'h09, 1'b1);
    @(negedge clk);
    check_output("midreset grant", {24'h0, bus1.grant}, 32'h0);
    check_output("midreset valid", {31'h0, bus1.grant_valid}, 32'h0);
    apply_stimulus(8'h09, 1'b0);
    @(negedge clk);
    check_output("midreset winner d1", {24'h0, bus1.grant}, 32'h01);
    check_output("midreset winner d0", {24'h0, bus0.grant}, 32'h01);

    // Random traffic, compared cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) req = 8'($urandom & $urandom);
        else req = 8'($urandom);
      end
      reset = ($urandom_range(0, 149) == 0);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
